countdown_timer: RTL and testbench

- Programmable down-counter/timer, the decrementing counterpart of the team's up-counter.
- Software writes a reload value, issues start, and the block counts down once per prescaled tick.
- Pulses done on reaching zero, then either stops (one-shot) or reloads and continues (periodic).
- Used as a timeout/interval source beside the free-running up-counters.

---
 rtl/countdown_timer_pkg.sv | 12 +
 rtl/countdown_timer_tick_prescaler.sv | 44 ++++
 rtl/countdown_timer.sv | 126 ++++++++++++
 tb/tb_countdown_timer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared types for the countdown timer: FSM state encoding and its width.
package countdown_timer_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

endpackage

// File: rtl/countdown_timer_tick_prescaler.sv
// Divides the tick enable by PRESCALE; step pulses on the tick that completes a group.
module tick_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic step
);

  if (PRESCALE == 1) begin : g_bypass
    logic unused_inputs;
    assign unused_inputs = &{1'b0, clk, reset, clear};
    assign step = tick;
  end else begin : g_div
    localparam int unsigned CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap;

    assign wrap = (cnt_q == LAST);
    assign step = tick & ~clear & wrap;

    always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
        cnt_d = '0;
      end else if (tick) begin
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Programmable down-counter: counts a reload value down once per prescaled tick,
// pulses done at terminal count, then stops (one-shot) or reloads (periodic).
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             tick,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             paused,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             paused_q, paused_d;
  logic             done_q, done_d;

  logic             pre_clear;
  logic             pre_tick;
  logic             step;

  // The prescaler only advances on ticks that RUN actually honours.
  assign pre_tick  = tick & (state_q == RUN) & ~pause & ~abort;
  assign pre_clear = abort | ((state_q == IDLE) & start);

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (pre_clear),
    .tick  (pre_tick),
    .step  (step)
  );

  always_comb begin
    state_d  = state_q;
    reload_d = load ? load_value : reload_q;
    count_d  = count_q;
    done_d   = 1'b0;

    if (abort) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (reload_q != '0) begin
              count_d = reload_q;
              state_d = RUN;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (step) begin
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - 1'b1;
            end else begin
              done_d = 1'b1;
              if (auto_reload && (reload_q != '0)) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = IDLE;
              end
            end
          end
        end
        PAUSE: begin
          if (start) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end

    busy_d   = (state_d != IDLE);
    paused_d = (state_d == PAUSE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      reload_q <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      paused_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      paused_q <= paused_d;
      done_q   <= done_d;
    end
  end

  assign count  = count_q;
  assign busy   = busy_q;
  assign paused = paused_q;
  assign done   = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: two instances (PRESCALE=1 and 4) driven in lockstep
// and compared every cycle against a behavioural timer model.
module tb_countdown_timer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         load, start, pause, abort, tick, auto_reload;
  logic [W-1:0] load_value;

  logic [W-1:0] count0, count1;
  logic         busy0, busy1, paused0, paused1, done0, done1;

  int total = 0;
  int bad   = 0;

  // Reference model: one slot per instance. mode 0=idle 1=running 2=paused.
  int ps     [2] = '{1, 4};
  int m_mode [2];
  int m_cnt  [2];
  int m_rel  [2];
  int m_pre  [2];
  int m_done [2];

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(W), .PRESCALE(1)) u_dut0 (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .abort(abort), .tick(tick),
    .auto_reload(auto_reload), .count(count0), .busy(busy0),
    .paused(paused0), .done(done0)
  );

  countdown_timer #(.WIDTH(W), .PRESCALE(4)) u_dut1 (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .abort(abort), .tick(tick),
    .auto_reload(auto_reload), .count(count1), .busy(busy1),
    .paused(paused1), .done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_cnt[i] = 0; m_rel[i] = 0; m_pre[i] = 0; m_done[i] = 0;
    end
  endtask

  task automatic model_step();
    int rel_old;
    for (int i = 0; i < 2; i++) begin
      rel_old   = m_rel[i];
      m_done[i] = 0;
      if (load) m_rel[i] = int'(load_value);
      if (abort) begin
        m_mode[i] = 0; m_cnt[i] = 0; m_pre[i] = 0;
      end else if (m_mode[i] == 0) begin
        if (start) begin
          m_pre[i] = 0;
          if (rel_old != 0) begin
            m_cnt[i] = rel_old; m_mode[i] = 1;
          end else begin
            m_done[i] = 1;
          end
        end
      end else if (m_mode[i] == 1) begin
        if (pause) begin
          m_mode[i] = 2;
        end else if (tick) begin
          m_pre[i]++;
          if (m_pre[i] == ps[i]) begin
            m_pre[i] = 0;
            if (m_cnt[i] > 1) begin
              m_cnt[i]--;
            end else begin
              m_done[i] = 1;
              if (auto_reload && rel_old != 0) m_cnt[i] = rel_old;
              else begin m_cnt[i] = 0; m_mode[i] = 0; end
            end
          end
        end
      end else begin
        if (start) m_mode[i] = 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("count0",  32'(count0),  32'(m_cnt[0]));
    chk("busy0",   32'(busy0),   32'(m_mode[0] != 0));
    chk("paused0", 32'(paused0), 32'(m_mode[0] == 2));
    chk("done0",   32'(done0),   32'(m_done[0]));
    chk("count1",  32'(count1),  32'(m_cnt[1]));
    chk("busy1",   32'(busy1),   32'(m_mode[1] != 0));
    chk("paused1", 32'(paused1), 32'(m_mode[1] == 2));
    chk("done1",   32'(done1),   32'(m_done[1]));
  endtask

  // One clock: apply inputs, advance the model, compare just after the edge.
  task automatic cyc(input logic ld, input logic [W-1:0] lv, input logic st,
                     input logic pa, input logic ab, input logic tk, input logic ar);
    load = ld; load_value = lv; start = st; pause = pa;
    abort = ab; tick = tk; auto_reload = ar;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n, input logic ar);
    for (int k = 0; k < n; k++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, ar);
  endtask

  initial begin
    int unsigned r;
    reset = 1'b0;
    load = 0; load_value = '0; start = 0; pause = 0; abort = 0; tick = 0; auto_reload = 0;
    model_reset();
    #12;
    compare_all();
    reset = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a RUN with count 0x5A.
    cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("run_5a", 32'(count0), 32'h5A);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("rst_count", 32'(count0), 32'h0);
    chk("rst_busy",  32'(busy0),  32'h0);
    chk("rst_done",  32'(done0),  32'h0);
    compare_all();
    @(posedge clk); #1;
    compare_all();
    reset = 1'b1;

    // One-shot from 3.
    cyc(1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("oneshot_start", 32'(count0), 32'd3);
    ticks(14, 1'b0);

    // Periodic from 2.
    cyc(1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    ticks(26, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Pause / resume from 5.
    cyc(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(2, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    ticks(10, 1'b0);
    chk("pause_hold",  32'(count0),  32'd3);
    chk("pause_flag",  32'(paused0), 32'd1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(22, 1'b0);

    // Zero reload start, then abort coinciding with a tick.
    cyc(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("zero_done", 32'(done0), 32'd1);
    chk("zero_busy", 32'(busy0), 32'd0);
    cyc(1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("abort_count", 32'(count0), 32'd0);

    // Load on the terminal tick: old reload used, new one from next period.
    cyc(1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    ticks(2, 1'b1);
    cyc(1'b1, 8'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("reload_old", 32'(count0), 32'd3);
    chk("reload_done", 32'(done0), 32'd1);
    ticks(3, 1'b1);
    chk("reload_new", 32'(count0), 32'd7);
    ticks(30, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      logic [W-1:0] lv;
      r  = $urandom;
      lv = ($urandom_range(0, 15) == 0) ? W'($urandom) : W'($urandom_range(0, 5));
      cyc(($urandom_range(0, 7) == 0), lv,
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 59) == 0), (r[1:0] != 2'b00), r[4]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
